// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO peripheral bus and the byte-copy DMA engine.
package mmio_pkg;

    localparam int MMIO_AW = 12;

    // Upper address nibble selects the peripheral on the MMIO bus
    localparam logic [3:0] SEL_BASIC_IO = 4'h0;
    localparam logic [3:0] SEL_UART     = 4'h1;
    localparam logic [3:0] SEL_TIMER    = 4'h2;
    localparam logic [3:0] SEL_VGA      = 4'h3;
    localparam logic [3:0] SEL_PS2      = 4'h4;
    localparam logic [3:0] SEL_SD       = 4'h5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_RD,
        ST_RWAIT,
        ST_WR,
        ST_FIN
    } dma_state_e;

endpackage

// File: rtl/mmio_dma_if.sv
// MMIO bus as seen by a bus initiator (master) and the bus mux/peripherals (slave).
interface mmio_dma_if #(
    parameter int AW = mmio_pkg::MMIO_AW
);
    logic          bus_req;
    logic          bus_gnt;
    logic          re;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data_write;
    logic [7:0]    data_read;

    modport master (
        output bus_req, re, we, addr, data_write,
        input  bus_gnt, data_read
    );

    modport slave (
        input  bus_req, re, we, addr, data_write,
        output bus_gnt, data_read
    );
endinterface

// File: rtl/mmio_dma.sv
// Byte-copy DMA engine: a second MMIO initiator that reads one byte and writes it
// back out per bus grant, with optional per-side address increment.
module mmio_dma
    import mmio_pkg::*;
#(
    parameter int AW = MMIO_AW,
    parameter int LW = 12
) (
    input  logic          system_clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
    input  logic          src_inc,
    input  logic          dst_inc,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    mmio_dma_if.master    bus
);

    dma_state_e    state_q, state_d;
    logic [AW-1:0] src_ptr_q, src_ptr_d;
    logic [AW-1:0] dst_ptr_q, dst_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          src_inc_q, src_inc_d;
    logic          dst_inc_q, dst_inc_d;
    logic [7:0]    data_q, data_d;
    logic          aborted_q, aborted_d;
    logic          fin_hold_q, fin_hold_d;
    logic          re_q, re_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? ST_FIN : ST_ARB;
                end
            end
            ST_ARB: begin
                if (abort) begin
                    state_d = ST_FIN;
                end else if (bus.bus_gnt) begin
                    state_d = ST_RD;
                end
            end
            ST_RD:    state_d = ST_RWAIT;
            ST_RWAIT: state_d = ST_WR;
            ST_WR:    state_d = (count_q == LW'(1)) ? ST_FIN : ST_ARB;
            ST_FIN: begin
                if (!fin_hold_q) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // A zero-length request spends one silent cycle in FIN so its done pulse
    // lands two cycles after start, like the first byte of a real transfer would.
    always_comb begin
        busy            = (state_q != ST_IDLE);
        done            = (state_q == ST_FIN) && !fin_hold_q;
        aborted         = aborted_q;
        bus.bus_req     = (state_q == ST_ARB) || (state_q == ST_RD) ||
                          (state_q == ST_RWAIT) || (state_q == ST_WR);
        bus.re          = re_q;
        bus.we          = we_q;
        bus.addr        = addr_q;
        bus.data_write  = data_q;
    end

    always_comb begin
        src_ptr_d  = src_ptr_q;
        dst_ptr_d  = dst_ptr_q;
        count_d    = count_q;
        src_inc_d  = src_inc_q;
        dst_inc_d  = dst_inc_q;
        data_d     = data_q;
        aborted_d  = aborted_q;
        fin_hold_d = fin_hold_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_ptr_d  = src;
                    dst_ptr_d  = dst;
                    count_d    = len;
                    src_inc_d  = src_inc;
                    dst_inc_d  = dst_inc;
                    aborted_d  = 1'b0;
                    fin_hold_d = (len == '0);
                end
            end
            ST_ARB: begin
                if (abort) begin
                    aborted_d = 1'b1;
                end
            end
            ST_RWAIT: data_d = bus.data_read;
            ST_WR: begin
                count_d   = count_q - LW'(1);
                src_ptr_d = src_ptr_q + AW'(src_inc_q);
                dst_ptr_d = dst_ptr_q + AW'(dst_inc_q);
            end
            ST_FIN:   fin_hold_d = 1'b0;
            default: ;
        endcase
    end

    // Strobes and address are registered off the next state so they line up
    // exactly with the RD and WR cycles; the address simply holds otherwise.
    always_comb begin
        re_d   = (state_d == ST_RD);
        we_d   = (state_d == ST_WR);
        addr_d = addr_q;
        if (state_d == ST_RD) begin
            addr_d = src_ptr_q;
        end else if (state_d == ST_WR) begin
            addr_d = dst_ptr_q;
        end
    end

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            src_ptr_q  <= '0;
            dst_ptr_q  <= '0;
            count_q    <= '0;
            src_inc_q  <= 1'b0;
            dst_inc_q  <= 1'b0;
            data_q     <= '0;
            aborted_q  <= 1'b0;
            fin_hold_q <= 1'b0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
        end else begin
            src_ptr_q  <= src_ptr_d;
            dst_ptr_q  <= dst_ptr_d;
            count_q    <= count_d;
            src_inc_q  <= src_inc_d;
            dst_inc_q  <= dst_inc_d;
            data_q     <= data_d;
            aborted_q  <= aborted_d;
            fin_hold_q <= fin_hold_d;
            re_q       <= re_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
        end
    end

endmodule

// File: tb/tb_mmio_dma.sv
// Directed bench for mmio_dma: a behavioural MMIO responder plus a scoreboard of
// expected read addresses and write address/data pairs.
module tb_mmio_dma;

    logic        system_clk = 1'b0;
    logic        reset_n    = 1'b0;
    logic        start      = 1'b0;
    logic [11:0] src        = '0;
    logic [11:0] dst        = '0;
    logic [11:0] len        = '0;
    logic        src_inc    = 1'b0;
    logic        dst_inc    = 1'b0;
    logic        abort      = 1'b0;
    logic        busy;
    logic        done;
    logic        aborted;

    mmio_dma_if #(.AW(12)) bus ();

    mmio_dma dut (
        .system_clk (system_clk),
        .reset_n    (reset_n),
        .start      (start),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .src_inc    (src_inc),
        .dst_inc    (dst_inc),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .bus        (bus)
    );

    always #5 system_clk = ~system_clk;

    int checks = 0;
    int passes = 0;

    logic [7:0]  mem [4096];
    logic [7:0]  port_data [8];
    int          port_idx = 0;
    logic [11:0] exp_rd [$];
    logic [19:0] exp_wr [$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Responder: data appears one cycle after the re cycle; 0x500 is a FIFO-like data port
    always @(posedge system_clk) begin
        if (bus.re) begin
            if (bus.addr == 12'h500) begin
                bus.data_read <= port_data[port_idx];
                port_idx <= port_idx + 1;
            end else begin
                bus.data_read <= mem[bus.addr];
            end
        end
    end

    always @(negedge system_clk) begin
        if (bus.we) begin
            if (exp_wr.size() == 0) begin
                checkOutput("unexpected write", {8'h0, bus.addr, bus.data_write}, 32'hFFFF_FFFF);
            end else begin
                checkOutput("write addr/data", {bus.addr, bus.data_write}, exp_wr.pop_front());
            end
        end
        if (bus.re) begin
            if (exp_rd.size() == 0) begin
                checkOutput("unexpected read", bus.addr, 32'hFFFF_FFFF);
            end else begin
                checkOutput("read addr", bus.addr, exp_rd.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [11:0] s, input logic [11:0] d, input logic [11:0] l,
                                 input logic si, input logic di);
        src     = s;
        dst     = d;
        len     = l;
        src_inc = si;
        dst_inc = di;
        start   = 1'b1;
    endtask

    // Called at a falling edge: that clock cycle is cycle 0 of the transfer
    task automatic run_transfer(input string name, input logic [11:0] s, input logic [11:0] d,
                                input logic [11:0] l, input logic si, input logic di,
                                input int exp_done, input int stall_at, input int abort_at,
                                input int exp_aborted);
        int done_at = -1;
        applyStimulus(s, d, l, si, di);
        for (int n = 1; n <= 200 && done_at < 0; n++) begin
            @(negedge system_clk);
            if (n == 1) begin
                start = 1'b0;
                checkOutput({name, " busy"}, busy, 1);
            end
            if (stall_at > 0 && n >= stall_at && n <= stall_at + 5) begin
                checkOutput({name, " stall req/re/we"}, {bus.bus_req, bus.re, bus.we}, 3'b100);
            end
            if (done) begin
                done_at = n;
                checkOutput({name, " aborted"}, aborted, exp_aborted);
            end
            if (stall_at > 0 && n == stall_at) bus.bus_gnt = 1'b0;
            if (stall_at > 0 && n == stall_at + 5) bus.bus_gnt = 1'b1;
            if (abort_at > 0 && n == abort_at) abort = 1'b1;
        end
        checkOutput({name, " done cycle"}, done_at, exp_done);
        @(negedge system_clk);
        abort = 1'b0;
        checkOutput({name, " busy after done"}, busy, 0);
        checkOutput({name, " reads left"}, exp_rd.size(), 0);
        checkOutput({name, " writes left"}, exp_wr.size(), 0);
    endtask

    initial begin
        bus.bus_gnt = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        port_data[0] = 8'h11; port_data[1] = 8'h22; port_data[2] = 8'h33; port_data[3] = 8'h44;
        port_data[4] = 8'h55; port_data[5] = 8'h66; port_data[6] = 8'h77; port_data[7] = 8'h88;

        #12;
        checkOutput("reset busy/done/aborted", {busy, done, aborted}, 0);
        checkOutput("reset req/re/we", {bus.bus_req, bus.re, bus.we}, 0);
        checkOutput("reset addr/data", {bus.addr, bus.data_write}, 0);
        @(negedge system_clk);
        reset_n = 1'b1;
        @(negedge system_clk);

        mem[12'h010] = 8'hA1; mem[12'h011] = 8'hB2; mem[12'h012] = 8'hC3;
        exp_rd = '{12'h010, 12'h011, 12'h012};
        exp_wr = '{{12'h020, 8'hA1}, {12'h021, 8'hB2}, {12'h022, 8'hC3}};
        run_transfer("inc copy", 12'h010, 12'h020, 12'd3, 1'b1, 1'b1, 13, 0, 0, 0);

        exp_rd = '{12'h500, 12'h500, 12'h500, 12'h500};
        exp_wr = '{{12'h300, 8'h11}, {12'h300, 8'h22}, {12'h300, 8'h33}, {12'h300, 8'h44}};
        run_transfer("drain", 12'h500, 12'h300, 12'd4, 1'b0, 1'b0, 17, 0, 0, 0);

        mem[12'h200] = 8'h05; mem[12'h201] = 8'h06; mem[12'h202] = 8'h07;
        exp_rd = '{12'h200, 12'h201, 12'h202};
        exp_wr = '{{12'h210, 8'h05}, {12'h211, 8'h06}, {12'h212, 8'h07}};
        run_transfer("grant stall", 12'h200, 12'h210, 12'd3, 1'b1, 1'b1, 18, 5, 0, 0);

        mem[12'h400] = 8'h99;
        exp_rd = '{12'h400};
        exp_wr = '{{12'h410, 8'h99}};
        run_transfer("abort", 12'h400, 12'h410, 12'd4, 1'b1, 1'b1, 6, 0, 3, 1);
        checkOutput("aborted sticky", aborted, 1);

        run_transfer("len0", 12'h123, 12'h456, 12'd0, 1'b1, 1'b1, 2, 0, 0, 0);

        mem[12'hFFF] = 8'h5A; mem[12'h000] = 8'h3C;
        exp_rd = '{12'hFFF, 12'h000};
        exp_wr = '{{12'h100, 8'h5A}, {12'h101, 8'h3C}};
        run_transfer("wrap", 12'hFFF, 12'h100, 12'd2, 1'b1, 1'b1, 9, 0, 0, 0);

        mem[12'h040] = 8'h77;
        exp_rd = '{12'h040};
        exp_wr = '{{12'h080, 8'h77}};
        applyStimulus(12'h040, 12'h080, 12'd4, 1'b1, 1'b1);
        for (int n = 1; n <= 4; n++) begin
            @(negedge system_clk);
            start = 1'b0;
        end
        checkOutput("we before reset", bus.we, 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset we/busy/req", {bus.we, busy, bus.bus_req}, 0);
        checkOutput("async reset addr", bus.addr, 0);
        exp_rd.delete();
        exp_wr.delete();
        @(negedge system_clk);
        reset_n = 1'b1;
        @(negedge system_clk);

        mem[12'h060] = 8'hE5;
        exp_rd = '{12'h060};
        exp_wr = '{{12'h070, 8'hE5}};
        run_transfer("post reset", 12'h060, 12'h070, 12'd1, 1'b1, 1'b1, 5, 0, 0, 0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mmio_dma.md
# mmio_dma

Byte-copy DMA engine that acts as a second initiator on the 12-bit MMIO peripheral bus. It issues read strobes and write strobes (`re`, `we`, `addr`, `data_write`) and samples the latched `data_read` return. Typical uses are moving a block between peripheral registers, or draining a fixed data port (SD, PS/2) into a VGA terminal port without CPU involvement. The CPU/DMA bus mux outside this block grants the bus through a req/gnt handshake.

## Interface
- `AW`, 12: MMIO address width.
- `LW`, 12: transfer length counter width.
- `system_clk` in 1: CPU/bus clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; accepted only in IDLE.
- `src` in AW: first source address, captured on `start`.
- `dst` in AW: first destination address, captured on `start`.
- `len` in LW: byte count, captured on `start`; 0 means no bus traffic.
- `src_inc` in 1: 1 increments the source per byte; 0 keeps it fixed (data port). Captured on `start`.
- `dst_inc` in 1: same rule for the destination.
- `abort` in 1: level; stops at the next byte boundary.
- `busy` out 1: high from the cycle after an accepted `start` until return to IDLE.
- `done` out 1: one-cycle pulse on completion or abort.
- `aborted` out 1: sticky; set with an abort-caused `done`, cleared on the next accepted `start`.
- `bus_req` out 1: bus request to the mux.
- `bus_gnt` in 1: grant from the mux.
- `re` out 1: MMIO read strobe.
- `we` out 1: MMIO write strobe.
- `addr` out AW: MMIO address.
- `data_write` out 8: write data.
- `data_read` in 8: latched MMIO read data.

## Operation
- Reset values: `busy`, `done`, `aborted`, `bus_req`, `re` and `we` are 0; `addr` and `data_write` are 0; FSM is in IDLE; counters are 0.
- States: IDLE, ARB, RD, RWAIT, WR, FIN.
- IDLE, on `start`:
  - Capture `src`, `dst`, `len`, `src_inc`, `dst_inc`; clear `aborted`.
  - If `len`==0, go to FIN; otherwise go to ARB.
- ARB:
  - `bus_req`=1.
  - If `abort` is high, go to FIN with `aborted` set.
  - Else if `bus_gnt`=1, go to RD. Otherwise wait indefinitely.
- RD: `re`=1, `addr`=src pointer, one cycle, then RWAIT.
- RWAIT:
  - `re`=0. `data_read` now holds the byte latched at the end of RD.
  - Capture `data_read` into the data register at the end of this cycle; go to WR.
- WR:
  - `we`=1, `addr`=dst pointer, `data_write`=data register, one cycle.
  - At the end of WR: remaining count −1; src pointer +1 if `src_inc`; dst pointer +1 if `dst_inc`.
  - If the remaining count reaches 0, go to FIN; otherwise go to ARB.
- FIN: `done`=1 for one cycle, `bus_req`=0, then IDLE.
- `bus_req` stays high from ARB through WR. It drops only in FIN or IDLE.
- Bus-drive rule: `re`, `we` and `addr` are registered outputs. When not in RD or WR, `re`=`we`=0. `addr` holds its last value.
- Grant rules:
  - The mux must not drop `bus_gnt` during RD, RWAIT or WR.
  - Grant is re-checked in ARB before every byte, so the CPU may reclaim the bus between bytes by holding `bus_gnt` low.
- Arithmetic: pointers wrap modulo 2^AW (0xFFF+1 → 0x000). The count is unsigned LW bits.
- Abort is only honoured in ARB. A byte already in RD, RWAIT or WR completes its write.
- `start` while `busy` is ignored. Captured parameters do not change mid-transfer.
- Reset mid-transfer: outputs return to reset values asynchronously. A strobe can be truncated; software re-issues the transfer.

## Timing
- Per byte with `bus_gnt` held high: 4 cycles (ARB, RD, RWAIT, WR).
- Transfer time: `start` at cycle 0 → first `re` at cycle 2 → first `we` at cycle 4 → `done` at cycle 4·len+1.
- `len`=0: `done` at cycle 2, and `re`/`we` are never asserted.
- `busy` deasserts in the cycle after the `done` pulse.
- Read latency assumed from the responder: data is valid exactly one cycle after the `re` cycle, held until the next `re`.

## Structure
- Shared package `mmio_pkg`:
  - FSM state enum.
  - `MMIO_AW`=12.
  - Peripheral select nibble constants (basic IO 0x0 … SD 0x5).
- Single module. Pointer/count update stays inline; no sub-module is warranted.

## Test plan
- Increment copy: src=0x010, dst=0x020, len=3, both inc, gnt tied 1, responder returns 0xA1/0xB2/0xC3 → writes 0x020=0xA1, 0x021=0xB2, 0x022=0xC3; `done` at cycle 13.
- Fixed-port drain: src=0x500, src_inc=0, dst=0x300, dst_inc=0, len=4 → four reads of 0x500 and four writes to 0x300, data order preserved.
- Grant stall: `bus_gnt` low for 5 cycles before byte 2 → ARB holds with `re`=`we`=0 and `bus_req`=1; total time is 4·len+1+5 cycles.
- Abort: `abort` raised during byte 1 RWAIT of len=4 → byte 1 write completes; `done` follows; `aborted`=1; only 1 write is issued.
- Edge cases:
  - len=0 → `done` at cycle 2 with no strobes.
  - src=0xFFF, inc, len=2 → reads 0xFFF then 0x000.
- Async reset asserted in WR → `we`, `busy` and `bus_req` drop immediately. After release, a new `start` runs correctly.
